cordic_iter_hs: RTL

Parametrised iterative CORDIC engine with rotate and vector modes, quadrant pre-rotation, fixed-count iteration and optional gain compensation. It runs one operation at a time behind valid/ready handshakes on both sides. It is the general-purpose sin/cos/atan2/magnitude engine for the NonLinear datapath, feeding the EKF prediction and measurement Jacobian stages.

---
 rtl/cordic_iter_hs.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/cordic_iter_hs.sv
// Iterative CORDIC engine (rotate / vector) with valid/ready handshakes on both sides.
// Define CORDIC_GAIN_COMP_EN to add the SCALE state that removes the CORDIC gain.
module cordic_iter_hs #(
    parameter int DW   = 17,
    parameter int AW   = 17,
    parameter int ITER = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode,
    input  logic [DW-1:0] xin,
    input  logic [DW-1:0] yin,
    input  logic [AW-1:0] zin,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] xout,
    output logic [DW-1:0] yout,
    output logic [AW-1:0] zout
);

    localparam int XW = DW + 2;
    localparam int PW = XW + DW;
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ITER  = 3'd2;
`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [2:0] S_SCALE = 3'd3;
`endif
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [IW-1:0]        LAST    = IW'(ITER - 1);
    localparam logic signed [AW-1:0] HALF_PI = AW'(2 ** (AW - 2));
    localparam logic signed [AW-1:0] PI_ANG  = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [PW-1:0] SMAX    = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN    = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    localparam int TSH_L = (AW >= 17) ? AW - 17 : 0;
    localparam int TSH_R = (AW < 17) ? 17 - AW : 0;

    logic [2:0]              state;
    logic [IW-1:0]           cnt;
    logic                    mode_r;
    logic                    zero_vec;
    logic signed [XW-1:0]    x, y;
    logic signed [AW-1:0]    z;
    logic signed [XW-1:0]    x_nx, y_nx;
    logic signed [AW-1:0]    z_nx, t_step;
    logic                    d_pos;

    // Table held with pi = 2^16 and rescaled to the configured angle width.
    function automatic logic signed [AW-1:0] atan_rom(input logic [IW-1:0] idx);
        int t;
        case (int'(idx))
            0:  t = 16384;
            1:  t = 9672;
            2:  t = 5110;
            3:  t = 2594;
            4:  t = 1302;
            5:  t = 652;
            6:  t = 326;
            7:  t = 163;
            8:  t = 81;
            9:  t = 41;
            10: t = 20;
            11: t = 10;
            12: t = 5;
            13: t = 3;
            14: t = 1;
            15: t = 1;
            default: t = 0;
        endcase
        t = t <<< TSH_L;
        t = (t + ((1 <<< TSH_R) >>> 1)) >>> TSH_R;
        return AW'(t);
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SMAX) return SMAX[DW-1:0];
        if (v < SMIN) return SMIN[DW-1:0];
        return v[DW-1:0];
    endfunction

    always_comb begin
        d_pos  = mode_r ? y[XW-1] : ~z[AW-1];
        t_step = atan_rom(cnt);
        x_nx   = d_pos ? x - (y >>> cnt) : x + (y >>> cnt);
        y_nx   = d_pos ? y + (x >>> cnt) : y - (x >>> cnt);
        z_nx   = d_pos ? z - t_step : z + t_step;
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int KC = $rtoi(0.607253 * (2.0 ** (DW - 2)) + 0.5);
    localparam logic signed [DW-1:0] KC_S = DW'(KC);

    logic signed [PW-1:0] px, py;
    assign px = PW'(x) * PW'(KC_S);
    assign py = PW'(y) * PW'(KC_S);
`else
    logic signed [PW-1:0] xr_nx, yr_nx;
    assign xr_nx = {{(PW-XW){x_nx[XW-1]}}, x_nx};
    assign yr_nx = {{(PW-XW){y_nx[XW-1]}}, y_nx};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            xout      <= '0;
            yout      <= '0;
            zout      <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            cnt       <= '0;
            mode_r    <= 1'b0;
            zero_vec  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        mode_r   <= mode;
                        x        <= {{2{xin[DW-1]}}, xin};
                        y        <= {{2{yin[DW-1]}}, yin};
                        z        <= zin;
                        zero_vec <= mode && (xin == '0) && (yin == '0);
                        in_ready <= 1'b0;
                        state    <= S_PRE;
                    end
                end
                // Fold the operand into the right half-plane so the iterations converge.
                S_PRE: begin
                    cnt   <= '0;
                    state <= S_ITER;
                    if (!mode_r) begin
                        if ((z > HALF_PI) || (z < -HALF_PI)) begin
                            x <= -x;
                            y <= -y;
                            z <= z + PI_ANG;
                        end
                    end else if (x[XW-1]) begin
                        x <= -x;
                        y <= -y;
                        z <= PI_ANG;
                    end else begin
                        z <= '0;
                    end
                end
                S_ITER: begin
                    x   <= x_nx;
                    y   <= y_nx;
                    z   <= z_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state     <= S_SCALE;
`else
                        xout      <= sat(xr_nx);
                        yout      <= sat(yr_nx);
                        zout      <= zero_vec ? '0 : z_nx;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
`endif
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_SCALE: begin
                    xout      <= sat(px >>> (DW - 2));
                    yout      <= sat(py >>> (DW - 2));
                    zout      <= zero_vec ? '0 : z;
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end
`endif
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
